wb_alu_xor_core: RTL
====================

WB_ALU_XOR_CORE -- requirements
Module: wb_alu_xor_core

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h3000_0000, giving the Wishbone base address (256-byte window).
REQ-002 The block SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-003 The block SHALL have port wb_rst_n, input, 1 bit: asynchronous active-low reset; the parent drives it as the inverse of wb_rst_i.
REQ-004 The block SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each input, 1 bit: the Wishbone strobe, cycle and write-enable.
REQ-005 The block SHALL have port wbs_sel_i, input, 4 bits: byte selects.
REQ-006 The block SHALL have ports wbs_adr_i and wbs_dat_i, each input, 32 bits: address and write data.
REQ-007 The block SHALL have port wbs_ack_o, output, 1 bit: transfer acknowledge.
REQ-008 The block SHALL have port wbs_dat_o, output, 32 bits: read data.
REQ-009 The block SHALL have port irq, output, 3 bits: irq[0] is the done interrupt; irq[2:1] are tied to 0.

Function
REQ-010 The block SHALL decode a transfer when wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8]==BASE_ADDR[31:8]).
REQ-011 The block SHALL assert wbs_ack_o for exactly one cycle, on the cycle after a decoded transfer, and SHALL NOT re-acknowledge while ack is high; it SHALL never stall.
REQ-012 The block SHALL use these byte offsets: 0x00 OPA (rw), 0x04 OPB (rw), 0x08 CTRL (w: op[2:0], start=bit 8), 0x0C STATUS (r: busy=0, done=1, err=2; w1c: done=1, err=2), 0x10 RES_LO (r), 0x14 RES_HI (r), 0x18 IRQ_EN (rw, bit 0).
REQ-013 Writes to OPA, OPB and IRQ_EN SHALL update only the bytes whose wbs_sel_i bit is set; CTRL and STATUS writes SHALL require wbs_sel_i[1:0] nonzero.
REQ-014 Reads at unmapped offsets SHALL return 32'h0; writes at unmapped offsets SHALL be acknowledged and ignored.
REQ-015 The opcodes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 MUL (unsigned 32x32->64), 7 reserved.
REQ-016 For ADD/SUB, RES_HI[0] SHALL carry the carry-out or borrow and RES_HI[31:1] SHALL be 0; for logic ops RES_HI SHALL be 0; for MUL, {RES_HI,RES_LO} SHALL hold the full product.
REQ-017 The FSM SHALL have the states IDLE, EXEC, MUL and FIN.
REQ-018 A CTRL write with start=1 in IDLE SHALL latch op, OPA and OPB, set busy on the next cycle, and move to MUL (op 6) or EXEC (otherwise).
REQ-019 EXEC SHALL last 1 cycle, MUL SHALL last exactly 32 cycles (shift-add), and each SHALL then pass to FIN.
REQ-020 FIN SHALL write RES_LO/RES_HI, set done, clear busy, and return to IDLE in 1 cycle; simple-op latency is therefore 2 cycles after the ack and MUL latency 33 cycles after the ack.
REQ-021 Opcode 7 SHALL produce a zero result, set err, and still set done.
REQ-022 A start write while busy SHALL be ignored and SHALL set err; the running operation SHALL be unaffected.
REQ-023 OPA/OPB writes during busy SHALL update the registers but SHALL NOT affect the latched operands.
REQ-024 If a STATUS w1c to done coincides with FIN, the set SHALL win.
REQ-025 The block SHALL drive irq[0] = done & IRQ_EN[0], registered, and level-held until done is cleared.
REQ-026 RES_LO/RES_HI SHALL hold their last value until the next FIN.

Reset
REQ-027 On wb_rst_n low, asynchronously: the FSM SHALL go to IDLE; OPA, OPB, RES_LO, RES_HI, IRQ_EN, busy, done, err, wbs_ack_o and irq SHALL be 0; and wbs_dat_o SHALL be 0.
REQ-028 A reset mid-MUL SHALL abort the operation, leave no partial result visible, and allow a new start to be accepted in the first cycle after release.

Structure
REQ-029 Package wb_alu_pkg SHALL hold the opcode enum, the register offset constants, the FSM state typedef, and the MUL iteration count (32).
REQ-030 The shift-add multiplier SHALL be the single sub-module alu_mul_seq (inputs start, a, b; outputs done and a 64-bit product); all other logic SHALL be inline.

Verification
REQ-031 The bench SHALL cover ADD: OPA=32'hFFFF_FFFF, OPB=1, start -> RES_LO=0, RES_HI=1, done=1 two cycles after the ack.
REQ-032 The bench SHALL cover XOR: 32'hA5A5_A5A5 ^ 32'h5A5A_5A5A -> RES_LO=32'hFFFF_FFFF, RES_HI=0; with IRQ_EN=1, irq[0]=1 until STATUS w1c of done.
REQ-033 The bench SHALL cover MUL: 32'hFFFF_FFFF * 32'hFFFF_FFFF -> busy for 32+1 cycles, RES_HI=32'hFFFF_FFFE, RES_LO=32'h0000_0001.
REQ-034 The bench SHALL cover start-while-busy: start XOR during MUL -> err=1 and the MUL product correct; STATUS write 32'h4 -> err=0.
REQ-035 The bench SHALL cover byte selects and unmapped access: an OPA write of 32'h1122_3344 with sel=4'b0101 over 0 -> OPA=32'h0022_0044; a read at offset 0x40 -> 0.
REQ-036 The bench SHALL cover reset mid-MUL: wb_rst_n low at cycle 10 of MUL -> all registers 0, no irq; a new ADD 2+3 -> RES_LO=5.

Source files
------------

// File: rtl/wb_alu_pkg.sv
// Shared types and constants for the Wishbone ALU block.
// Holds opcodes, register map, FSM states and op helpers.
package wb_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_MUL  = 3'd6,
    OP_RSV  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2,
    S_FIN  = 2'd3
  } alu_state_e;

  localparam logic [7:0] OFF_OPA    = 8'h00;
  localparam logic [7:0] OFF_OPB    = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_RES_LO = 8'h10;
  localparam logic [7:0] OFF_RES_HI = 8'h14;
  localparam logic [7:0] OFF_IRQ_EN = 8'h18;

  localparam int MUL_ITERS = 32;

  // Merge write data into a register byte by byte
  function automatic logic [31:0] bmerge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Single-cycle ops; {hi, lo}, hi[0] carries carry/borrow
  function automatic logic [63:0] alu_simple(
    input alu_op_e     op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    logic [63:0] r;
    s = '0;
    r = '0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = {31'b0, s};
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = {31'b0, s};
      end
      OP_AND:  r = {32'b0, a & b};
      OP_OR:   r = {32'b0, a | b};
      OP_XOR:  r = {32'b0, a ^ b};
      OP_XNOR: r = {32'b0, ~(a ^ b)};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier, unsigned 32x32->64.
// Runs MUL_ITERS cycles after a start pulse.
module alu_mul_seq
  import wb_alu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [63:0] o_prod
);

  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [5:0]  r_cnt;
  logic        r_run;

  // Done is high during the cycle of the last iteration
  assign o_done = r_run & (r_cnt == 6'd1);
  assign o_prod = r_acc;

  // Load operands on start, then one add-shift step per cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_acc    <= '0;
      r_mcand  <= {32'b0, i_a};
      r_mplier <= i_b;
      r_cnt    <= 6'(MUL_ITERS);
      r_run    <= 1'b1;
    end else if (r_run) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 6'd1;
      if (r_cnt == 6'd1) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_alu_xor_core.sv
// Wishbone slave ALU: operand regs, control FSM,
// sequential multiplier and a level done interrupt.
module wb_alu_xor_core
  import wb_alu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  logic        r_ack;
  logic [31:0] r_dat;
  logic [31:0] r_opa;
  logic [31:0] r_opb;
  logic        r_irq_en;
  logic        r_irq;

  alu_state_e  r_state;
  alu_op_e     r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_res_lo;
  logic [31:0] r_res_hi;
  logic        r_done;
  logic        r_err;

  logic        w_dec;
  logic        w_wr;
  logic        w_rd;
  logic [7:0]  w_off;
  logic        w_sel_lo;
  logic        w_start;
  logic        w_go;
  logic        w_mul_go;
  logic        w_stat_wr;
  logic        w_busy;
  logic        w_fin;
  logic        w_mul_done;
  logic [63:0] w_prod;
  logic [63:0] w_simple;
  logic [31:0] w_rdata;

  assign w_dec = wbs_stb_i & wbs_cyc_i & ~r_ack &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr     = w_dec & wbs_we_i;
  assign w_rd     = w_dec & ~wbs_we_i;
  assign w_off    = wbs_adr_i[7:0];
  assign w_sel_lo = |wbs_sel_i[1:0];
  assign w_start  = w_wr & w_sel_lo &
                    (w_off == OFF_CTRL) & wbs_dat_i[8];
  assign w_go     = w_start & (r_state == S_IDLE);
  assign w_mul_go = w_go & (wbs_dat_i[2:0] == OP_MUL);
  assign w_stat_wr = w_wr & w_sel_lo & (w_off == OFF_STATUS);
  assign w_busy   = (r_state != S_IDLE);
  assign w_fin    = (r_state == S_FIN);
  assign w_simple = alu_simple(r_op, r_a, r_b);

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq       = {2'b00, r_irq};

  alu_mul_seq u_mul (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_rst_n),
    .i_start (w_mul_go),
    .i_a     (r_opa),
    .i_b     (r_opb),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  // Read data mux; unmapped and write-only offsets read as zero
  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_OPA:    w_rdata = r_opa;
      OFF_OPB:    w_rdata = r_opb;
      OFF_STATUS: w_rdata = {29'b0, r_err, r_done, w_busy};
      OFF_RES_LO: w_rdata = r_res_lo;
      OFF_RES_HI: w_rdata = r_res_hi;
      OFF_IRQ_EN: w_rdata = {31'b0, r_irq_en};
      default:    w_rdata = '0;
    endcase
  end

  // Bus side: single-cycle ack, read capture, operand writes
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack    <= 1'b0;
      r_dat    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_irq_en <= 1'b0;
    end else begin
      r_ack <= w_dec;
      r_dat <= w_rd ? w_rdata : 32'h0;
      if (w_wr && w_off == OFF_OPA)
        r_opa <= bmerge(r_opa, wbs_dat_i, wbs_sel_i);
      if (w_wr && w_off == OFF_OPB)
        r_opb <= bmerge(r_opb, wbs_dat_i, wbs_sel_i);
      if (w_wr && w_off == OFF_IRQ_EN && wbs_sel_i[0])
        r_irq_en <= wbs_dat_i[0];
    end
  end

  // Control FSM with result, done and err registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= OP_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      // w1c first so a same-cycle set below wins
      if (w_stat_wr && wbs_dat_i[1]) r_done <= 1'b0;
      if (w_stat_wr && wbs_dat_i[2]) r_err  <= 1'b0;
      if (w_start && w_busy) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_op    <= alu_op_e'(wbs_dat_i[2:0]);
            r_a     <= r_opa;
            r_b     <= r_opb;
            r_state <= w_mul_go ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: r_state <= S_FIN;
        S_MUL: begin
          if (w_mul_done) r_state <= S_FIN;
        end
        S_FIN: begin
          if (r_op == OP_MUL) begin
            r_res_lo <= w_prod[31:0];
            r_res_hi <= w_prod[63:32];
          end else begin
            r_res_lo <= w_simple[31:0];
            r_res_hi <= w_simple[63:32];
          end
          if (r_op == OP_RSV) r_err <= 1'b1;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) r_irq <= 1'b0;
    else           r_irq <= r_done & r_irq_en;
  end

  logic w_unused;
  assign w_unused = w_fin;

endmodule
